dcs_reply_packer: RTL and testbench

//  Downstream of the DCS reply-ack stage. Captures each dcs_cmd_update pulse with its 64-bit
//  {addr,data} reply and buffers it. Batches replies into framed 32-bit word bursts for the
//  UDP transmit path using a valid/ready handshake.
//  A frame flushes when BATCH replies are queued, or when the idle timeout expires with

---
 rtl/dcs_reply_pkg.sv | 23 ++
 rtl/dcs_reply_fifo.sv | 67 ++++++
 rtl/dcs_reply_packer.sv | 199 +++++++++++++++++++
 tb/tb_dcs_reply_packer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcs_reply_pkg.sv
// Shared types and constants for the DCS reply packer.
// Used by dcs_reply_fifo and dcs_reply_packer.
package dcs_reply_pkg;

   // Frame FSM states. TRL exists only in builds with DCS_REPLY_CRC_EN.
   typedef enum logic [2:0] {
      IDLE,
      HDR,
      ADDR,
      DATA,
      TRL
   } state_t;

   // Default upper half of every frame header word.
   localparam logic [15:0] DCS_HDR_TAG = 16'hDC5A;

   // One buffered reply as captured from the reply-ack stage.
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } reply_t;

endpackage

// File: rtl/dcs_reply_fifo.sv
// Synchronous first-word-fall-through reply FIFO.
// The head entry is visible on dout whenever empty is low; rd_en pops it.
// Writes while full and reads while empty are ignored.
module dcs_reply_fifo
   import dcs_reply_pkg::*;
#(
   parameter int FIFO_AW = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic [63:0]        din,
   input  logic               rd_en,
   output logic [63:0]        dout,
   output logic               full,
   output logic               empty,
   output logic [FIFO_AW:0]   level
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);

   reply_t             mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic               do_wr;
   logic               do_rd;

   assign full  = (level == FULL_LEVEL);
   assign empty = (level == '0);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   // The head is read straight from storage, so it is stable until popped.
   assign dout = mem[rd_ptr];

   // Storage write.
   // NOTE: the payload array has no reset; only the pointers and level define
   // which entries are meaningful, and leaving it unreset lets it map to RAM.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy tracking; a simultaneous push and pop keeps the level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/dcs_reply_packer.sv
// DCS reply packer: buffers {addr,data} replies and emits them as framed
// 32-bit word bursts on a valid/ready interface.
// Frame: header {HDR_TAG, seq, n}, then n pairs of (addr, data) words.
// Optional macro DCS_REPLY_CRC_EN appends a TRL word (XOR of all frame words)
// that carries tx_last instead of the final data word.
module dcs_reply_packer
   import dcs_reply_pkg::*;
#(
   parameter int          FIFO_AW   = 3,
   parameter int          BATCH     = 4,
   parameter int          FLUSH_TMO = 1000,
   parameter logic [15:0] HDR_TAG   = DCS_HDR_TAG
) (
   input  logic               dcsclk,
   input  logic               reset_n,
   input  logic               dcs_cmd_update,
   input  logic [63:0]        dcs_cmd_reply,
   output logic [31:0]        tx_data,
   output logic               tx_valid,
   input  logic               tx_ready,
   output logic               tx_last,
   output logic [FIFO_AW:0]   fifo_level,
   output logic [15:0]        drop_cnt
);

   localparam int               TMO_W    = $clog2(FLUSH_TMO) + 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FLUSH_TMO - 1);
   localparam logic [FIFO_AW:0] BATCH_N  = (FIFO_AW + 1)'(BATCH);
   localparam logic [FIFO_AW:0] N_ONE    = (FIFO_AW + 1)'(1);

   logic [1:0]       rst_sync;
   logic             rst_n;
   state_t           state;
   logic [FIFO_AW:0] n_left;
   logic [FIFO_AW:0] n_new;
   logic [7:0]       seq;
   logic [31:0]      hdr_word;
   logic [TMO_W-1:0] tmo;
   logic             fifo_full;
   logic             fifo_empty;
   reply_t           head;
   logic             push_ok;
   logic             flush;
   logic             accept;
   logic             pop;
`ifdef DCS_REPLY_CRC_EN
   logic [31:0]      crc;
`endif

   // Reset is asserted asynchronously and released on a clock edge.
   always_ff @(posedge dcsclk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_n = rst_sync[1];

   assign push_ok = dcs_cmd_update && !fifo_full;
   assign accept  = tx_valid && tx_ready;
   assign pop     = (state == DATA) && accept;
   assign flush   = (state == IDLE) && !fifo_empty &&
                    ((fifo_level >= BATCH_N) || (tmo == TMO_LAST));
   assign n_new   = (fifo_level >= BATCH_N) ? BATCH_N : fifo_level;

   dcs_reply_fifo #(
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk   (dcsclk),
      .rst_n (rst_n),
      .wr_en (dcs_cmd_update),
      .din   (dcs_cmd_reply),
      .rd_en (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Word selection from registered state only: the FIFO head does not move
   // until the DATA word is accepted, so the word is stable during a stall.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      tx_data = '0;
      case (state)
         HDR:     tx_data = hdr_word;
         ADDR:    tx_data = head.addr;
         DATA:    tx_data = head.data;
`ifdef DCS_REPLY_CRC_EN
         TRL:     tx_data = crc;
`endif
         default: tx_data = '0;
      endcase
   end

   // Frame sequencer: header, then addr/data pairs, then optional trailer.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge dcsclk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tx_valid <= 1'b0;
         tx_last  <= 1'b0;
         seq      <= '0;
         n_left   <= '0;
         hdr_word <= '0;
`ifdef DCS_REPLY_CRC_EN
         crc      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (flush) begin
                  n_left   <= n_new;
                  hdr_word <= {HDR_TAG, seq, 8'(n_new)};
                  tx_valid <= 1'b1;
                  tx_last  <= 1'b0;
                  state    <= HDR;
`ifdef DCS_REPLY_CRC_EN
                  crc      <= {HDR_TAG, seq, 8'(n_new)};
`endif
               end
            end
            HDR: begin
               if (accept) begin
                  state <= ADDR;
               end
            end
            ADDR: begin
               if (accept) begin
                  state <= DATA;
`ifdef DCS_REPLY_CRC_EN
                  crc   <= crc ^ tx_data;
`else
                  tx_last <= (n_left == N_ONE);
`endif
               end
            end
            DATA: begin
               if (accept) begin
                  n_left <= n_left - 1'b1;
`ifdef DCS_REPLY_CRC_EN
                  crc    <= crc ^ tx_data;
`endif
                  if (n_left != N_ONE) begin
                     state <= ADDR;
                  end else begin
`ifdef DCS_REPLY_CRC_EN
                     state   <= TRL;
                     tx_last <= 1'b1;
`else
                     state    <= IDLE;
                     tx_valid <= 1'b0;
                     tx_last  <= 1'b0;
                     seq      <= seq + 8'd1;
`endif
                  end
               end
            end
            TRL: begin
               if (accept) begin
                  state    <= IDLE;
                  tx_valid <= 1'b0;
                  tx_last  <= 1'b0;
                  seq      <= seq + 8'd1;
               end
            end
            default: begin
               state    <= IDLE;
               tx_valid <= 1'b0;
               tx_last  <= 1'b0;
            end
         endcase
      end
   end

   // Idle timer: restarts on every stored reply and on frame start.
   always_ff @(posedge dcsclk or negedge rst_n) begin
      if (!rst_n) begin
         tmo <= '0;
      end else if (push_ok || flush) begin
         tmo <= '0;
      end else if ((state == IDLE) && !fifo_empty && (tmo != TMO_LAST)) begin
         tmo <= tmo + 1'b1;
      end
   end

   // Overflow counter: a strobe that finds the FIFO full is lost and counted.
   always_ff @(posedge dcsclk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (dcs_cmd_update && fifo_full && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_dcs_reply_packer.sv
// Self-checking bench for dcs_reply_packer.
// Stimulus pushes expected frame words into a scoreboard queue; a monitor on
// the falling clock edge pops and compares every accepted word and checks
// that stalled words stay put.
module tb_dcs_reply_packer;

   localparam int FIFO_AW   = 3;
   localparam int BATCH     = 4;
   localparam int FLUSH_TMO = 16;

   logic              dcsclk = 1'b0;
   logic              reset_n = 1'b0;
   logic              dcs_cmd_update = 1'b0;
   logic [63:0]       dcs_cmd_reply = '0;
   logic              tx_ready = 1'b0;
   logic [31:0]       tx_data;
   logic              tx_valid;
   logic              tx_last;
   logic [FIFO_AW:0]  fifo_level;
   logic [15:0]       drop_cnt;

   int          checks = 0;
   int          errors = 0;
   logic [32:0] exp_q [$];
   logic [63:0] pend [$];
   logic [7:0]  model_seq = 8'd0;
   bit          rand_ready = 1'b0;

   always #5 dcsclk = ~dcsclk;

   dcs_reply_packer #(
      .FIFO_AW   (FIFO_AW),
      .BATCH     (BATCH),
      .FLUSH_TMO (FLUSH_TMO),
      .HDR_TAG   (16'hDC5A)
   ) dut (
      .dcsclk         (dcsclk),
      .reset_n        (reset_n),
      .dcs_cmd_update (dcs_cmd_update),
      .dcs_cmd_reply  (dcs_cmd_reply),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .tx_last        (tx_last),
      .fifo_level     (fifo_level),
      .drop_cnt       (drop_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Advance one clock; inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge dcsclk);
      #1;
      if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic push(input logic [63:0] d, input bit stored);
      dcs_cmd_update = 1'b1;
      dcs_cmd_reply  = d;
      tick();
      dcs_cmd_update = 1'b0;
      if (stored) pend.push_back(d);
   endtask

   // Queue the expected words of a frame built from the n oldest pending replies.
   task automatic expect_frame(input int n);
      logic [31:0] hdr;
      logic [31:0] x;
      logic [63:0] e;
      bit          last;
      hdr = {16'hDC5A, model_seq, 8'(n)};
      x   = hdr;
      exp_q.push_back({1'b0, hdr});
      for (int i = 0; i < n; i++) begin
         e = pend.pop_front();
`ifdef DCS_REPLY_CRC_EN
         last = 1'b0;
`else
         last = (i == n - 1);
`endif
         exp_q.push_back({1'b0, e[63:32]});
         exp_q.push_back({last, e[31:0]});
         x = x ^ e[63:32] ^ e[31:0];
      end
`ifdef DCS_REPLY_CRC_EN
      exp_q.push_back({1'b1, x});
`endif
      model_seq = model_seq + 8'd1;
   endtask

   task automatic wait_valid(input int budget, output int cycles);
      cycles = 0;
      while (!tx_valid && cycles < budget) begin
         tick();
         cycles++;
      end
      if (!tx_valid) check("wait_valid_timeout", 64'(tx_valid), 64'd1);
   endtask

   task automatic wait_drain(input int budget);
      int c = 0;
      while ((exp_q.size() != 0 || tx_valid) && c < budget) begin
         tick();
         c++;
      end
      if (c >= budget) check("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   // Scoreboard monitor.
   logic        stalled = 1'b0;
   logic [31:0] held_data;
   logic        held_last;
   always @(negedge dcsclk) begin
      logic [32:0] e;
      if (!reset_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("hold_valid", 64'(tx_valid), 64'd1);
            check("hold_data", 64'(tx_data), 64'(held_data));
            check("hold_last", 64'(tx_last), 64'(held_last));
         end
         stalled = 1'b0;
         if (tx_valid) begin
            if (tx_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_word", 64'(exp_q.size()), 64'd1);
               end else begin
                  e = exp_q.pop_front();
                  check("word", 64'({tx_last, tx_data}), 64'(e));
               end
            end else begin
               stalled   = 1'b1;
               held_data = tx_data;
               held_last = tx_last;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;

      // Reset state
      reset_n = 1'b0;
      repeat (3) tick();
      check("rst_valid", 64'(tx_valid), 64'd0);
      check("rst_last", 64'(tx_last), 64'd0);
      check("rst_data", 64'(tx_data), 64'd0);
      check("rst_level", 64'(fifo_level), 64'd0);
      check("rst_drop", 64'(drop_cnt), 64'd0);
      reset_n = 1'b1;
      repeat (3) tick();

      // 1: single reply flushes on idle timeout
      tx_ready = 1'b1;
      push(64'h0000_1234_DEAD_BEEF, 1'b1);
      check("t1_level", 64'(fifo_level), 64'd1);
      expect_frame(1);
      wait_valid(200, cyc);
      check("t1_latency", 64'(cyc), 64'(FLUSH_TMO));
      wait_drain(50);
      check("t1_level_end", 64'(fifo_level), 64'd0);

      // 2: full batch flushes without waiting
      push(64'h1111_0001_AAAA_0001, 1'b1);
      push(64'h1111_0002_AAAA_0002, 1'b1);
      push(64'h1111_0003_AAAA_0003, 1'b1);
      push(64'h1111_0004_AAAA_0004, 1'b1);
      expect_frame(4);
      wait_valid(50, cyc);
      check("t2_latency", 64'(cyc), 64'd1);
      wait_drain(50);
      check("t2_level_end", 64'(fifo_level), 64'd0);

      // 3: random backpressure; late pushes form the next frame
      rand_ready = 1'b1;
      push(64'h2222_0001_BBBB_0001, 1'b1);
      push(64'h2222_0002_BBBB_0002, 1'b1);
      push(64'h2222_0003_BBBB_0003, 1'b1);
      push(64'h2222_0004_BBBB_0004, 1'b1);
      expect_frame(4);
      wait_valid(50, cyc);
      push(64'h3333_0005_CCCC_0005, 1'b1);
      push(64'h3333_0006_CCCC_0006, 1'b1);
      expect_frame(2);
      wait_drain(1000);
      rand_ready = 1'b0;
      tx_ready   = 1'b1;
      check("t3_level_end", 64'(fifo_level), 64'd0);

      // 4: overflow while stalled, then two full frames and nothing more
      tx_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         push({32'h4444_0000 + 32'(i), 32'hD000_0000 + 32'(i)}, i < 8);
      end
      tick();
      check("t4_level", 64'(fifo_level), 64'd8);
      check("t4_drop", 64'(drop_cnt), 64'd2);
      expect_frame(4);
      expect_frame(4);
      tx_ready = 1'b1;
      wait_drain(200);
      repeat (FLUSH_TMO + 8) tick();
      check("t4_no_third_frame", 64'(tx_valid), 64'd0);
      check("t4_level_end", 64'(fifo_level), 64'd0);

      // 5: reset while a DATA word is presented
      tx_ready = 1'b0;
      push(64'h5555_0001_EEEE_0001, 1'b1);
      push(64'h5555_0002_EEEE_0002, 1'b1);
      push(64'h5555_0003_EEEE_0003, 1'b1);
      push(64'h5555_0004_EEEE_0004, 1'b1);
      expect_frame(4);
      wait_valid(50, cyc);
      tx_ready = 1'b1;
      tick();
      tick();
      tx_ready = 1'b0;
      check("t5_data_word", 64'(tx_data), 64'h0000_0000_EEEE_0001);
      #2;
      reset_n = 1'b0;
      #1;
      check("t5_async_valid", 64'(tx_valid), 64'd0);
      check("t5_async_level", 64'(fifo_level), 64'd0);
      check("t5_async_data", 64'(tx_data), 64'd0);
      exp_q.delete();
      pend.delete();
      model_seq = 8'd0;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (3) tick();
      check("t5_drop_after", 64'(drop_cnt), 64'd0);
      check("t5_valid_after", 64'(tx_valid), 64'd0);

      // 6: 257 single-reply frames, seq starts at 0 and wraps FF -> 00
      tx_ready = 1'b1;
      for (int i = 0; i < 257; i++) begin
         push({32'hA000_0000 | 32'(i), ~32'(i)}, 1'b1);
         expect_frame(1);
         wait_drain(100);
      end
      check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
      check("t6_level_end", 64'(fifo_level), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
